// File: rtl/full_adder_pkg.sv
// Shared constants and golden arithmetic model for the full_adder block.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH = 64;

  // {carry, sum} at the widest legal width; callers zero-extend operands
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin
  );
    return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One full-adder bit cell used as a link of the ripple chain.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with combinational and one-cycle registered outputs.
// FULL_ADDER_OVF_EN adds signed-overflow outputs ovf and ovf_q.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign carry = c[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Carry into and out of the sign bit disagree on two's-complement overflow
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances, table and random.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       a1, b1, cin1;
  logic       sum1, carry1, sum1_q, carry1_q;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8, sum8_q;
  logic       carry8, carry8_q;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf1_q, ovf8, ovf8_q;
`endif

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a1),
    .b       (b1),
    .cin     (cin1),
    .sum     (sum1),
    .carry   (carry1),
    .sum_q   (sum1_q),
    .carry_q (carry1_q)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf     (ovf1),
    .ovf_q   (ovf1_q)
`endif
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a8),
    .b       (b8),
    .cin     (cin8),
    .sum     (sum8),
    .carry   (carry8),
    .sum_q   (sum8_q),
    .carry_q (carry8_q)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf     (ovf8),
    .ovf_q   (ovf8_q)
`endif
  );

  task automatic check(input string name, input logic [64:0] act,
                       input logic [64:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic carry;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [64:0] ref_v;
    logic [7:0]  exp_s;
    logic        exp_c;
    int          sres;
    logic        exp_o;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0;
    a8 = 0; b8 = 0; cin8 = 0;

    // exhaustive 1-bit truth table while reset is held
    for (int i = 0; i < 8; i++) begin
      a1 = tbl[i].a; b1 = tbl[i].b; cin1 = tbl[i].cin;
      #1;
      check($sformatf("tt%0d_sum", i), 65'(sum1), 65'(tbl[i].sum));
      check($sformatf("tt%0d_carry", i), 65'(carry1), 65'(tbl[i].carry));
      #9;
    end

    @(negedge clk);
    check("rst_sum1_q", 65'(sum1_q), 65'(0));
    check("rst_carry1_q", 65'(carry1_q), 65'(0));
    check("rst_sum8_q", 65'(sum8_q), 65'(0));
    check("rst_carry8_q", 65'(carry8_q), 65'(0));

    // registered latency: result appears only after the next edge
    rst_n = 1'b1;
    a1 = 1; b1 = 1; cin1 = 0;
    #1;
    check("lat_pre_carry_q", 65'(carry1_q), 65'(0));
    check("lat_comb_carry", 65'(carry1), 65'(1));
    @(posedge clk); #1;
    check("lat_sum_q", 65'(sum1_q), 65'(0));
    check("lat_carry_q", 65'(carry1_q), 65'(1));

    // synchronous reset dropped between edges
    @(negedge clk);
    a1 = 1; b1 = 0; cin1 = 0;
    @(posedge clk); #1;
    check("sr_sum_q_set", 65'(sum1_q), 65'(1));
    #1 rst_n = 1'b0;
    #1;
    check("sr_sum_q_hold", 65'(sum1_q), 65'(1));
    check("sr_comb_live", 65'(sum1), 65'(1));
    @(posedge clk); #1;
    check("sr_sum_q_clr", 65'(sum1_q), 65'(0));
    check("sr_comb_after", 65'(sum1), 65'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit wrap-around corners
    a8 = 8'hFF; b8 = 8'h01; cin8 = 0;
    #1;
    check("wrap1_sum", 65'(sum8), 65'(8'h00));
    check("wrap1_carry", 65'(carry8), 65'(1));
`ifdef FULL_ADDER_OVF_EN
    check("wrap1_ovf", 65'(ovf8), 65'(0));
`endif
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1;
    #1;
    check("wrap2_sum", 65'(sum8), 65'(8'hFF));
    check("wrap2_carry", 65'(carry8), 65'(1));
`ifdef FULL_ADDER_OVF_EN
    check("wrap2_ovf", 65'(ovf8), 65'(0));
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 0;
    #1;
    check("ovf_pos", 65'(ovf8), 65'(1));
    check("ovf_q_pre", 65'(ovf8_q), 65'(0));
    @(posedge clk); #1;
    check("ovf_q_post", 65'(ovf8_q), 65'(1));
    check("ovf1_q_tt", 65'(ovf1_q), 65'(0));
`endif

    // random vectors against the arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      ref_v = fa_ref(64'(a8), 64'(b8), cin8);
      exp_s = ref_v[7:0];
      exp_c = ref_v[8];
      sres = int'($signed(a8)) + int'($signed(b8)) + int'(cin8);
      exp_o = (sres > 127) || (sres < -128);
      #1;
      check("rnd_sum", 65'(sum8), 65'(exp_s));
      check("rnd_carry", 65'(carry8), 65'(exp_c));
`ifdef FULL_ADDER_OVF_EN
      check("rnd_ovf", 65'(ovf8), 65'(exp_o));
`endif
      @(posedge clk); #1;
      check("rnd_sum_q", 65'(sum8_q), 65'(exp_s));
      check("rnd_carry_q", 65'(carry8_q), 65'(exp_c));
`ifdef FULL_ADDER_OVF_EN
      check("rnd_ovf_q", 65'(ovf8_q), 65'(exp_o));
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
